// File: rtl/rx_frame_ctrl.sv
// Receive-path frame sequencer: closes a frame after an idle timeout, queues frame records
// for the CPU in a small show-ahead fifo, and measures the answer delay between frames.
module rx_frame_ctrl #(
  parameter int INFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p_Enable_i,
  input  logic               p_FrameFunctionEnable_i,
  input  logic [15:0]        RxTimeOutSet_i,
  input  logic               BaudSig_i,
  input  logic               p_ByteWritten_i,
  input  logic               p_ParityErr_i,
  input  logic               p_FrameErr_i,
  input  logic [11:0]        millisecond_stamp_i,
  input  logic [3:0]         acqurate_stamp_i,
  input  logic               n_RxFrameInfo_Rd_i,
  output logic [CNT_W+17:0]  frame_info_o,
  output logic               p_RxFrame_Empty_o,
  output logic               p_FrameInfoOver_o,
  output logic [15:0]        AnsDelayTime_o
);

  localparam int AW = (INFO_DEPTH > 1) ? $clog2(INFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RECV, CLOSE} state_t;

  typedef struct packed {
    logic             parErr;
    logic             frmErr;
    logic [CNT_W-1:0] cnt;
    logic [11:0]      ms;
    logic [3:0]       acc;
  } info_t;

  state_t state, stateNxt;
  info_t  cur;
  logic [15:0] idleCnt;
  logic [16:0] idleInc, toLimit;
  logic        en, byteEn;
  logic        startFrame, addByte, idleTick, loadAns;

  logic [15:0] ansCnt;
  logic        ansRun;

  info_t       mem [INFO_DEPTH];
  logic [AW-1:0] wPtr, rPtr;
  logic [AW:0]   level;
  logic          push, pop, full, doWrite, drop;

  assign en      = p_Enable_i & p_FrameFunctionEnable_i;
  assign byteEn  = p_ByteWritten_i & en;
  assign idleInc = {1'b0, idleCnt} + 17'd1;
  assign toLimit = (RxTimeOutSet_i == 16'd0) ? 17'd1 : {1'b0, RxTimeOutSet_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt   = state;
    startFrame = 1'b0;
    addByte    = 1'b0;
    idleTick   = 1'b0;
    loadAns    = 1'b0;
    case (state)
      IDLE: if (byteEn) begin
        startFrame = 1'b1;
        loadAns    = 1'b1;
        stateNxt   = RECV;
      end
      RECV: begin
        if (!en) stateNxt = IDLE;
        else if (p_ByteWritten_i) addByte = 1'b1;
        else if (BaudSig_i) begin
          idleTick = 1'b1;
          if (idleInc >= toLimit) stateNxt = CLOSE;
        end
      end
      CLOSE: begin
        // A byte landing in the close cycle opens the next frame immediately
        if (byteEn) begin
          startFrame = 1'b1;
          stateNxt   = RECV;
        end else begin
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= '0;
      idleCnt <= '0;
    end else if (startFrame) begin
      cur.cnt    <= CNT_W'(1);
      cur.ms     <= millisecond_stamp_i;
      cur.acc    <= acqurate_stamp_i;
      cur.parErr <= p_ParityErr_i;
      cur.frmErr <= p_FrameErr_i;
      idleCnt    <= '0;
    end else if (addByte) begin
      if (cur.cnt != '1) cur.cnt <= cur.cnt + CNT_W'(1);
      cur.ms     <= millisecond_stamp_i;
      cur.acc    <= acqurate_stamp_i;
      cur.parErr <= cur.parErr | p_ParityErr_i;
      cur.frmErr <= cur.frmErr | p_FrameErr_i;
      idleCnt    <= '0;
    end else if (idleTick) begin
      idleCnt <= idleInc[15:0];
    end
  end

  // Answer delay only starts counting once a frame has closed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ansCnt         <= '0;
      ansRun         <= 1'b0;
      AnsDelayTime_o <= '0;
    end else if (state == CLOSE) begin
      ansCnt <= '0;
      ansRun <= 1'b1;
    end else if (state == IDLE) begin
      if (loadAns) AnsDelayTime_o <= ansCnt;
      else if (BaudSig_i && ansRun && ansCnt != 16'hFFFF) ansCnt <= ansCnt + 16'd1;
    end
  end

  assign push    = (state == CLOSE);
  assign full    = (level == (AW+1)'(INFO_DEPTH));
  assign pop     = !n_RxFrameInfo_Rd_i && !p_RxFrame_Empty_o;
  assign doWrite = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (doWrite) mem[wPtr] <= cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wPtr              <= '0;
      rPtr              <= '0;
      level             <= '0;
      p_FrameInfoOver_o <= 1'b0;
    end else begin
      if (doWrite) wPtr <= wPtr + AW'(1);
      if (pop)     rPtr <= rPtr + AW'(1);
      case ({doWrite, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (drop)     p_FrameInfoOver_o <= 1'b1;
      else if (pop) p_FrameInfoOver_o <= 1'b0;
    end
  end

  assign p_RxFrame_Empty_o = (level == '0);
  assign frame_info_o      = p_RxFrame_Empty_o ? '0 : mem[rPtr];

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed vector table, hand sequences, and randomized traffic
// checked against a queue-based frame model.
module tb_rx_frame_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        enable = 1'b1, ffEnable = 1'b1;
  logic [15:0] timeout = 16'd4;
  logic        baud = 1'b0, byteW = 1'b0, parE = 1'b0, frmE = 1'b0;
  logic [11:0] ms = '0;
  logic [3:0]  acc = '0;
  logic        nRd = 1'b1;
  logic [33:0] info;
  logic        empty, over;
  logic [15:0] ansOut;

  int total = 0, bad = 0;

  rx_frame_ctrl #(.INFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .p_Enable_i(enable), .p_FrameFunctionEnable_i(ffEnable),
    .RxTimeOutSet_i(timeout), .BaudSig_i(baud),
    .p_ByteWritten_i(byteW), .p_ParityErr_i(parE), .p_FrameErr_i(frmE),
    .millisecond_stamp_i(ms), .acqurate_stamp_i(acc),
    .n_RxFrameInfo_Rd_i(nRd),
    .frame_info_o(info), .p_RxFrame_Empty_o(empty),
    .p_FrameInfoOver_o(over), .AnsDelayTime_o(ansOut)
  );

  always #5 clk = ~clk;

  // Reference model: frame bookkeeping in plain integers, info fifo as a queue
  logic [33:0] mq[$];
  bit  mInFrame, mClose, mPar, mFrm, mOver, mAnsRun;
  int  mCnt, mIdle, mAnsCnt, mAnsOut;
  logic [11:0] mMs;
  logic [3:0]  mAcc;

  task automatic modelReset();
    mq.delete();
    mInFrame = 0; mClose = 0; mPar = 0; mFrm = 0; mOver = 0; mAnsRun = 0;
    mCnt = 0; mIdle = 0; mAnsCnt = 0; mAnsOut = 0; mMs = '0; mAcc = '0;
  endtask

  task automatic startFrame();
    mInFrame = 1; mCnt = 1; mIdle = 0; mMs = ms; mAcc = acc; mPar = parE; mFrm = frmE;
  endtask

  task automatic modelStep();
    bit en, push, pop;
    int lim, lvl;
    logic [33:0] rec;
    en   = enable && ffEnable;
    lim  = (timeout == 0) ? 1 : int'(timeout);
    push = mClose;
    rec  = {mPar, mFrm, 16'(mCnt), mMs, mAcc};
    pop  = !nRd && mq.size() > 0;
    if (mClose) begin
      mClose = 0; mAnsRun = 1; mAnsCnt = 0;
      if (byteW && en) startFrame();
    end else if (!mInFrame) begin
      if (byteW && en) begin mAnsOut = mAnsCnt; startFrame(); end
      else if (baud && mAnsRun && mAnsCnt < 65535) mAnsCnt++;
    end else if (!en) begin
      mInFrame = 0;
    end else if (byteW) begin
      if (mCnt < 65535) mCnt++;
      mIdle = 0; mMs = ms; mAcc = acc; mPar |= parE; mFrm |= frmE;
    end else if (baud) begin
      mIdle++;
      if (mIdle >= lim) begin mInFrame = 0; mClose = 1; end
    end
    lvl = mq.size();
    if (pop) begin void'(mq.pop_front()); mOver = 0; end
    if (push) begin
      if (lvl == DEPTH && !pop) mOver = 1;
      else mq.push_back(rec);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    if (mq.size() > 0) chk("head", 64'(info), 64'(mq[0]));
    chk("over", 64'(over), 64'(mOver));
    chk("ansDelay", 64'(ansOut), 64'(mAnsOut));
  endtask

  task automatic step(input logic b, input logic pe, input logic fe, input logic bd, input logic rdn);
    byteW = b; parE = pe; frmE = fe; baud = bd; nRd = rdn;
    modelStep();
    @(posedge clk); #1;
    byteW = 0; parE = 0; frmE = 0; baud = 0; nRd = 1;
    checkModel();
  endtask

  typedef struct {
    logic b, pe, bd, rdn;
    logic [11:0] ms;
    logic [3:0]  acc;
    logic        expEmpty;
    logic [33:0] expInfo;
  } vec_t;
  vec_t tbl[$];

  initial begin
    // 3 bytes / timeout 4, then parity on byte 2 of 5
    tbl.push_back('{1, 0, 0, 1, 12'd100, 4'd1, 1, 34'd0});
    tbl.push_back('{1, 0, 0, 1, 12'd110, 4'd2, 1, 34'd0});
    tbl.push_back('{1, 0, 0, 1, 12'd123, 4'd7, 1, 34'd0});
    tbl.push_back('{0, 0, 1, 1, 12'd0,   4'd0, 1, 34'd0});
    tbl.push_back('{0, 0, 1, 1, 12'd0,   4'd0, 1, 34'd0});
    tbl.push_back('{0, 0, 1, 1, 12'd0,   4'd0, 1, 34'd0});
    tbl.push_back('{0, 0, 1, 1, 12'd0,   4'd0, 1, 34'd0});
    tbl.push_back('{0, 0, 0, 1, 12'd0,   4'd0, 0, {1'b0, 1'b0, 16'd3, 12'd123, 4'd7}});
    tbl.push_back('{0, 0, 0, 0, 12'd0,   4'd0, 1, 34'd0});
    tbl.push_back('{1, 0, 0, 1, 12'd10,  4'd0, 1, 34'd0});
    tbl.push_back('{1, 1, 0, 1, 12'd20,  4'd1, 1, 34'd0});
    tbl.push_back('{1, 0, 0, 1, 12'd30,  4'd2, 1, 34'd0});
    tbl.push_back('{1, 0, 0, 1, 12'd40,  4'd5, 1, 34'd0});
    tbl.push_back('{1, 0, 0, 1, 12'd200, 4'd3, 1, 34'd0});
    tbl.push_back('{0, 0, 1, 1, 12'd0,   4'd0, 1, 34'd0});
    tbl.push_back('{0, 0, 1, 1, 12'd0,   4'd0, 1, 34'd0});
    tbl.push_back('{0, 0, 1, 1, 12'd0,   4'd0, 1, 34'd0});
    tbl.push_back('{0, 0, 1, 1, 12'd0,   4'd0, 1, 34'd0});
    tbl.push_back('{0, 0, 0, 1, 12'd0,   4'd0, 0, {1'b1, 1'b0, 16'd5, 12'd200, 4'd3}});
    tbl.push_back('{0, 0, 0, 0, 12'd0,   4'd0, 1, 34'd0});

    modelReset();
    #1;
    chk("rstEmpty", 64'(empty), 64'd1);
    chk("rstOver", 64'(over), 64'd0);
    chk("rstAns", 64'(ansOut), 64'd0);
    chk("rstInfo", 64'(info), 64'd0);
    @(negedge clk); rst = 0;

    foreach (tbl[i]) begin
      ms = tbl[i].ms; acc = tbl[i].acc;
      step(tbl[i].b, tbl[i].pe, 1'b0, tbl[i].bd, tbl[i].rdn);
      chk("tblEmpty", 64'(empty), 64'(tbl[i].expEmpty));
      if (!tbl[i].expEmpty) chk("tblInfo", 64'(info), 64'(tbl[i].expInfo));
    end

    // Five frames with no reads: frame k carries k bytes, the fifth is dropped
    timeout = 16'd2;
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < k; j++) step(1, 0, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1);
    end
    chk("ovfOver", 64'(over), 64'd1);
    chk("ovfHead", 64'(info[31:16]), 64'd1);
    step(0, 0, 0, 0, 0);
    chk("ovfClr", 64'(over), 64'd0);
    chk("ovfHead2", 64'(info[31:16]), 64'd2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ovfLeft", 64'(empty), 64'd0);
    chk("ovfHead4", 64'(info[31:16]), 64'd4);
    step(0, 0, 0, 0, 0);
    chk("ovfEmpty", 64'(empty), 64'd1);

    // Byte coinciding with the 4th BaudSig keeps the frame open
    timeout = 16'd4;
    step(1, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1, 1);
    chk("coinOpen", 64'(empty), 64'd1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("coinClose", 64'(empty), 64'd0);
    chk("coinCnt", 64'(info[31:16]), 64'd2);
    step(0, 0, 0, 0, 0);

    // Ten idle ticks between frames
    repeat (10) step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    chk("ansDelay10", 64'(ansOut), 64'd10);
    repeat (4) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Enable drop aborts the frame
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    enable = 0;
    step(0, 0, 0, 0, 1);
    enable = 1;
    repeat (6) step(0, 0, 0, 1, 1);
    chk("abortEmpty", 64'(empty), 64'd1);

    // Timeout 0 behaves as 1
    timeout = 16'd0;
    ms = 12'd999; acc = 4'd9;
    step(1, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("to0Empty", 64'(empty), 64'd0);
    chk("to0Info", 64'(info), 64'({1'b0, 1'b1, 16'd1, 12'd999, 4'd9}));
    step(0, 0, 0, 0, 0);

    // Async reset mid-frame with a record waiting
    timeout = 16'd1;
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    #2 rst = 1;
    #1;
    chk("arstEmpty", 64'(empty), 64'd1);
    chk("arstOver", 64'(over), 64'd0);
    chk("arstAns", 64'(ansOut), 64'd0);
    modelReset();
    #3 rst = 0;
    repeat (3) step(0, 0, 0, 1, 1);
    chk("arstNoFrame", 64'(empty), 64'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(99) < 5) timeout = 16'($urandom_range(5));
      enable = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      ms  = 12'($urandom_range(999));
      acc = 4'($urandom_range(9));
      step($urandom_range(99) < 30, $urandom_range(99) < 10, $urandom_range(99) < 10,
           $urandom_range(99) < 45, !($urandom_range(99) < 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
